// File: rtl/int_prio_ctrl_if.sv
// rtl/int_prio_ctrl_if.sv - interrupt source / CPU-side bundle for int_prio_ctrl
interface int_prio_ctrl_if #(
    parameter int N = 10
);
    localparam int IDW = (N > 1) ? $clog2(N) : 1;

    logic [N-1:0]   int_in;
    logic [N-1:0]   int_en;
    logic [N-1:0]   int_mode;
    logic           int_ack;
    logic           int_out;
    logic [IDW-1:0] int_id;
    logic [N-1:0]   int_pending;

    // Interrupt agent: drives requests, enables, modes and the ack.
    modport master (
        output int_in,
        output int_en,
        output int_mode,
        output int_ack,
        input  int_out,
        input  int_id,
        input  int_pending
    );

    // Controller side.
    modport slave (
        input  int_in,
        input  int_en,
        input  int_mode,
        input  int_ack,
        output int_out,
        output int_id,
        output int_pending
    );
endinterface

// File: rtl/int_prio_ctrl.sv
// rtl/int_prio_ctrl.sv - N-source fixed-priority interrupt controller; optional INT_PRIO_SYNC_EN input synchroniser
module int_prio_ctrl #(
    parameter int N = 10
) (
    input  logic            clk,
    input  logic            rst,
    int_prio_ctrl_if.slave  bus
);
    localparam int IDW = (N > 1) ? $clog2(N) : 1;

    // Presentation FSM: IDLE waits for work, ASSERT holds one ID, GAP forces a low cycle.
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ASSERT = 2'd1;
    localparam logic [1:0] ST_GAP    = 2'd2;

    logic [N-1:0]   s;
    logic [N-1:0]   prev_q;
    logic [N-1:0]   lvl_q;
    logic [N-1:0]   lvl_d;
    logic [N-1:0]   edge_pend_q;
    logic [N-1:0]   edge_pend_d;
    logic [N-1:0]   rise;
    logic [N-1:0]   clr;
    logic [N-1:0]   eligible;
    logic [1:0]     state_q;
    logic [1:0]     state_d;
    logic [IDW-1:0] id_q;
    logic [IDW-1:0] id_d;
    logic [IDW-1:0] winner;
    logic           any_elig;
    logic           id_elig;

`ifdef INT_PRIO_SYNC_EN
    logic [N-1:0] sync1_q;
    logic [N-1:0] sync2_q;

    // Two-flop synchroniser per source so asynchronous requesters are safe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= bus.int_in;
            sync2_q <= sync1_q;
        end
    end

    assign s = sync2_q;
`else
    assign s = bus.int_in;
`endif

    // A rise is seen against the previous sample; prev resets low, so a line
    // already high at reset release is treated as a fresh edge.
    assign rise = s & ~prev_q;

    // Ack only clears the edge-pending bit of the ID currently presented.
    always_comb begin
        clr = '0;
        if (state_q == ST_ASSERT && bus.int_ack) begin
            for (int i = 0; i < N; i++) begin
                if (id_q == IDW'(i)) begin
                    clr[i] = 1'b1;
                end
            end
        end
    end

    // Edge capture: a new rise beats a same-cycle ack; level-mode bits are held at 0.
    // Level view: registered sample, only for level-mode sources. Enables are not
    // applied here so masked events are kept until unmasked.
    always_comb begin
        edge_pend_d = bus.int_mode & (rise | (edge_pend_q & ~clr));
        lvl_d       = s & ~bus.int_mode;
    end

    // Request capture registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_q      <= '0;
            lvl_q       <= '0;
            edge_pend_q <= '0;
        end else begin
            prev_q      <= s;
            lvl_q       <= lvl_d;
            edge_pend_q <= edge_pend_d;
        end
    end

    assign eligible = (edge_pend_q | lvl_q) & bus.int_en;

    // Find-first on eligible (lowest index wins) and whether the held ID is still live.
    always_comb begin
        winner   = '0;
        any_elig = |eligible;
        id_elig  = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                winner = IDW'(i);
            end
        end
        for (int i = 0; i < N; i++) begin
            if (id_q == IDW'(i) && eligible[i]) begin
                id_elig = 1'b1;
            end
        end
    end

    // Next-state logic; the presented ID is never preempted, only acked or withdrawn.
    always_comb begin
        state_d = state_q;
        id_d    = id_q;
        case (state_q)
            ST_IDLE: begin
                if (any_elig) begin
                    state_d = ST_ASSERT;
                    id_d    = winner;
                end
            end
            ST_ASSERT: begin
                if (bus.int_ack) begin
                    state_d = ST_GAP;
                end else if (!id_elig) begin
                    state_d = ST_IDLE;
                end
            end
            ST_GAP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // FSM state and latched ID.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            id_q    <= '0;
        end else begin
            state_q <= state_d;
            id_q    <= id_d;
        end
    end

    assign bus.int_out     = (state_q == ST_ASSERT);
    assign bus.int_id      = id_q;
    assign bus.int_pending = edge_pend_q | lvl_q;

endmodule

// File: tb/tb_int_prio_ctrl.sv
// tb/tb_int_prio_ctrl.sv - scoreboard bench for int_prio_ctrl
module tb_int_prio_ctrl;
    localparam int N = 10;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;
    int   exp_q[$];
    logic prev_out;

    int_prio_ctrl_if #(.N(N)) bus ();

    int_prio_ctrl #(.N(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_out(input logic level, input int budget);
        int k;
        k = 0;
        while (bus.int_out !== level && k < budget) begin
            step(1);
            k++;
        end
        if (bus.int_out !== level) check("wait_out_timeout", 32'(bus.int_out), 32'(level));
    endtask

    task automatic do_ack();
        bus.int_ack = 1'b1;
        step(1);
        bus.int_ack = 1'b0;
    endtask

    // Scoreboard: every new presentation must match the next queued ID.
    always @(negedge clk) begin
        if (!rst && bus.int_out === 1'b1 && prev_out !== 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_present", 32'(bus.int_id), 32'hFFFF_FFFF);
            end else begin
                check("present_id", 32'(bus.int_id), 32'(exp_q.pop_front()));
            end
        end
        prev_out = bus.int_out;
    end

    initial begin
        n_checks = 0;
        n_fail   = 0;
        prev_out = 1'b0;
        rst          = 1'b1;
        bus.int_in   = '1;
        bus.int_en   = '1;
        bus.int_mode = '1;
        bus.int_ack  = 1'b0;

        // Reset with all inputs high, then every source captures an edge on release.
        step(3);
        check("rst_out", 32'(bus.int_out), 32'd0);
        check("rst_id", 32'(bus.int_id), 32'd0);
        check("rst_pending", 32'(bus.int_pending), 32'd0);
        rst = 1'b0;
        for (int i = 0; i < N; i++) exp_q.push_back(i);
        step(1);
        check("rel_out_1edge", 32'(bus.int_out), 32'd0);
        check("rel_pending", 32'(bus.int_pending), 32'h3FF);
        step(1);
        check("rel_out_2edge", 32'(bus.int_out), 32'd1);
        check("rel_id", 32'(bus.int_id), 32'd0);
        for (int i = 0; i < N; i++) begin
            wait_out(1'b1, 8);
            do_ack();
            check("drain_gap", 32'(bus.int_out), 32'd0);
        end
        bus.int_in = '0;
        step(3);
        check("drain_idle", 32'(bus.int_out), 32'd0);
        check("drain_pending", 32'(bus.int_pending), 32'd0);

        // Single edge on source 3, held without ack.
        bus.int_in[3] = 1'b1;
        exp_q.push_back(3);
        step(1);
        bus.int_in[3] = 1'b0;
        check("single_1edge", 32'(bus.int_out), 32'd0);
        step(1);
        check("single_out", 32'(bus.int_out), 32'd1);
        check("single_id", 32'(bus.int_id), 32'd3);
        for (int i = 0; i < 20; i++) begin
            step(1);
            check("single_hold", {bus.int_out, 27'd0, bus.int_id}, {1'b1, 27'd0, 4'd3});
        end
        do_ack();
        check("single_ack_low", 32'(bus.int_out), 32'd0);
        step(5);
        check("single_stay_low", 32'(bus.int_out), 32'd0);
        check("single_pending", 32'(bus.int_pending), 32'd0);

        // Priority: 2 and 7 together; 2 first, then 7 after the forced gap.
        bus.int_in[2] = 1'b1;
        bus.int_in[7] = 1'b1;
        exp_q.push_back(2);
        exp_q.push_back(7);
        step(1);
        bus.int_in[2] = 1'b0;
        bus.int_in[7] = 1'b0;
        step(1);
        check("prio_first", 32'(bus.int_id), 32'd2);
        do_ack();
        check("prio_gap", 32'(bus.int_out), 32'd0);
        step(1);
        check("prio_idle", 32'(bus.int_out), 32'd0);
        step(1);
        check("prio_second_out", 32'(bus.int_out), 32'd1);
        check("prio_second_id", 32'(bus.int_id), 32'd7);
        do_ack();
        step(4);
        check("prio_done_out", 32'(bus.int_out), 32'd0);
        check("prio_done_pending", 32'(bus.int_pending), 32'd0);

        // Level source 5: re-fires after ack, withdraws when dropped.
        bus.int_mode[5] = 1'b0;
        bus.int_in[5]   = 1'b1;
        exp_q.push_back(5);
        wait_out(1'b1, 6);
        check("lvl_id", 32'(bus.int_id), 32'd5);
        exp_q.push_back(5);
        do_ack();
        check("lvl_gap", 32'(bus.int_out), 32'd0);
        check("lvl_pending_kept", 32'(bus.int_pending[5]), 32'd1);
        step(2);
        check("lvl_refire", 32'(bus.int_out), 32'd1);
        bus.int_in[5] = 1'b0;
        step(1);
        check("lvl_drop_still", 32'(bus.int_out), 32'd1);
        step(1);
        check("lvl_withdraw", 32'(bus.int_out), 32'd0);
        check("lvl_id_hold", 32'(bus.int_id), 32'd5);
        bus.int_mode[5] = 1'b1;
        step(3);
        check("lvl_quiet", 32'(bus.int_out), 32'd0);

        // Masked edge on 4 is retained and fires once enabled.
        bus.int_en[4] = 1'b0;
        bus.int_in[4] = 1'b1;
        step(1);
        bus.int_in[4] = 1'b0;
        step(4);
        check("mask_out", 32'(bus.int_out), 32'd0);
        check("mask_pending", 32'(bus.int_pending), 32'h010);
        bus.int_en[4] = 1'b1;
        exp_q.push_back(4);
        step(1);
        check("unmask_out", 32'(bus.int_out), 32'd1);
        check("unmask_id", 32'(bus.int_id), 32'd4);
        do_ack();
        step(3);

        // Ack and a new rise on 6 in the same cycle: the new edge survives.
        bus.int_in[6] = 1'b1;
        exp_q.push_back(6);
        step(1);
        bus.int_in[6] = 1'b0;
        wait_out(1'b1, 6);
        bus.int_in[6] = 1'b1;
        exp_q.push_back(6);
        do_ack();
        bus.int_in[6] = 1'b0;
        check("coll_gap", 32'(bus.int_out), 32'd0);
        check("coll_pending", 32'(bus.int_pending), 32'h040);
        wait_out(1'b1, 6);
        check("coll_id", 32'(bus.int_id), 32'd6);
        do_ack();
        step(5);
        check("coll_idle", 32'(bus.int_out), 32'd0);
        check("coll_pending_clr", 32'(bus.int_pending), 32'd0);

        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
